// File: rtl/key_pkg.sv
// Shared types and defaults for the two-key button conditioner.
package key_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDebPress,
    StHeld,
    StLongHeld,
    StDebRel
  } key_state_e;

  // 10 ms and 1 s at 50 MHz.
  localparam int unsigned DebCyclesDefault  = 500000;
  localparam int unsigned LongCyclesDefault = 50000000;

  function automatic int unsigned cnt_width(int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Conditioned key event bundle: level plus the three one-cycle event pulses.
interface key_conditioner_if #(
  parameter int unsigned N = 2
) ();

  logic [N-1:0] key_down;
  logic [N-1:0] key_press;
  logic [N-1:0] key_release;
  logic [N-1:0] key_long;

  modport master (output key_down, output key_press, output key_release, output key_long);
  modport slave  (input  key_down, input  key_press, input  key_release, input  key_long);

endinterface

// File: rtl/key_channel.sv
// One key: 2-flop synchronizer, debounce/long-press FSM and saturating counters.
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DebCyclesDefault,
  parameter int unsigned LONG_CYCLES = LongCyclesDefault
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_n_i,
  key_conditioner_if.master  ev
);

  localparam int unsigned DebW  = cnt_width(DEB_CYCLES);
  localparam int unsigned HoldW = cnt_width(LONG_CYCLES);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEB_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             raw_pressed;
  key_state_e       state_q, state_d;
  logic [DebW-1:0]  deb_q, deb_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             long_flag_q, long_flag_d;
  logic             down_q, down_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             lng_q, lng_d;

  assign raw_pressed = ~sync2_q;

  always_comb begin
    state_d     = state_q;
    deb_d       = deb_q;
    hold_d      = hold_q;
    long_flag_d = long_flag_q;
    down_d      = down_q;
    press_d     = 1'b0;
    rel_d       = 1'b0;
    lng_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (raw_pressed) begin
          state_d = StDebPress;
          deb_d   = '0;
        end
      end
      StDebPress: begin
        if (!raw_pressed) begin
          state_d = StIdle;
        end else if (deb_q == DebLast) begin
          state_d     = StHeld;
          press_d     = 1'b1;
          down_d      = 1'b1;
          hold_d      = '0;
          long_flag_d = 1'b0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      StHeld: begin
        // Release wins over a coincident long-press terminal count.
        if (!raw_pressed) begin
          state_d = StDebRel;
          deb_d   = '0;
        end else if (hold_q == HoldLast) begin
          state_d     = StLongHeld;
          lng_d       = 1'b1;
          long_flag_d = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StLongHeld: begin
        if (!raw_pressed) begin
          state_d = StDebRel;
          deb_d   = '0;
        end
      end
      StDebRel: begin
        if (raw_pressed) begin
          state_d = long_flag_q ? StLongHeld : StHeld;
        end else if (deb_q == DebLast) begin
          state_d = StIdle;
          rel_d   = 1'b1;
          down_d  = 1'b0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= StIdle;
      deb_q       <= '0;
      hold_q      <= '0;
      long_flag_q <= 1'b0;
      down_q      <= 1'b0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      lng_q       <= 1'b0;
    end else begin
      sync1_q     <= key_n_i;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      deb_q       <= deb_d;
      hold_q      <= hold_d;
      long_flag_q <= long_flag_d;
      down_q      <= down_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      lng_q       <= lng_d;
    end
  end

  assign ev.key_down    = down_q;
  assign ev.key_press   = press_q;
  assign ev.key_release = rel_q;
  assign ev.key_long    = lng_q;

endmodule

// File: rtl/key_conditioner.sv
// Two independent debounced board buttons with press/release/long-press events.
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DebCyclesDefault,
  parameter int unsigned LONG_CYCLES = LongCyclesDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       KEY0,
  input  logic       KEY1,
  output logic [1:0] key_down,
  output logic [1:0] key_press,
  output logic [1:0] key_release,
  output logic [1:0] key_long
);

  logic [1:0] keys_n;
  assign keys_n = {KEY1, KEY0};

  for (genvar g = 0; g < 2; g++) begin : g_ch
    key_conditioner_if #(.N(1)) ev_if ();

    key_channel #(
      .DEB_CYCLES (DEB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_n_i(keys_n[g]),
      .ev     (ev_if.master)
    );

    assign key_down[g]    = ev_if.key_down;
    assign key_press[g]   = ev_if.key_press;
    assign key_release[g] = ev_if.key_release;
    assign key_long[g]    = ev_if.key_long;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: table of press lengths plus hand-built corner sequences.
module tb_key_conditioner;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic key0  = 1'b1;
  logic key1  = 1'b1;

  key_conditioner_if #(.N(2)) mon_if ();

  key_conditioner #(
    .DEB_CYCLES (4),
    .LONG_CYCLES(20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .KEY0       (key0),
    .KEY1       (key1),
    .key_down   (mon_if.key_down),
    .key_press  (mon_if.key_press),
    .key_release(mon_if.key_release),
    .key_long   (mon_if.key_long)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
  } ev_t;

  // Delays are counted from the first edge that samples the key low (0 = no event).
  typedef struct {
    int ch;
    int low_len;
    int press_at;
    int long_at;
    int rel_at;
  } vec_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic monitor();
    ev_t e;
    if ((mon_if.key_press | mon_if.key_release | mon_if.key_long) != 2'b00) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got press=%b rel=%b long=%b at cycle %0d, required none",
                 mon_if.key_press, mon_if.key_release, mon_if.key_long, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("event_press", {30'd0, mon_if.key_press}, {30'd0, e.press});
        check("event_release", {30'd0, mon_if.key_release}, {30'd0, e.rel});
        check("event_long", {30'd0, mon_if.key_long}, {30'd0, e.lng});
      end
    end
  endtask

  // Sample on the falling edge, then drive just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input int c, input logic [1:0] p, input logic [1:0] r, input logic [1:0] l);
    ev_t e;
    e.cyc   = c;
    e.press = p;
    e.rel   = r;
    e.lng   = l;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int n);
    ticks(n);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic set_key(input int ch, input logic v);
    if (ch == 0) key0 = v;
    else         key1 = v;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_down"}, {30'd0, mon_if.key_down}, 32'd0);
    check({name, "_press"}, {30'd0, mon_if.key_press}, 32'd0);
    check({name, "_release"}, {30'd0, mon_if.key_release}, 32'd0);
    check({name, "_long"}, {30'd0, mon_if.key_long}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vecs[7];
    int         e;
    logic [1:0] m;

    vecs = '{
      '{0, 3, 0, 0, 0},
      '{1, 4, 0, 0, 0},
      '{1, 5, 6, 0, 11},
      '{0, 10, 6, 0, 16},
      '{0, 24, 6, 0, 30},
      '{1, 25, 6, 26, 31},
      '{0, 40, 6, 26, 46}
    };

    #2;
    check_outputs_zero("reset");
    ticks(3);
    rst_n = 1'b1;
    ticks(3);

    for (int i = 0; i < 7; i++) begin
      e = cyc + 1;
      m = 2'b01 << vecs[i].ch;
      set_key(vecs[i].ch, 1'b0);
      if (vecs[i].press_at != 0) push(e + vecs[i].press_at, m, 2'b00, 2'b00);
      if (vecs[i].long_at != 0)  push(e + vecs[i].long_at, 2'b00, 2'b00, m);
      if (vecs[i].rel_at != 0)   push(e + vecs[i].rel_at, 2'b00, m, 2'b00);
      ticks(vecs[i].low_len);
      set_key(vecs[i].ch, 1'b1);
      drain("vector_drained", 14);
    end

    // KEY1 bounces, then settles low.
    for (int k = 0; k < 3; k++) begin
      key1 = 1'b0;
      ticks(2);
      key1 = 1'b1;
      ticks(2);
    end
    e    = cyc + 1;
    key1 = 1'b0;
    push(e + 6, 2'b10, 2'b00, 2'b00);
    ticks(10);
    check("bounce_down", {30'd0, mon_if.key_down}, 32'd2);
    key1 = 1'b1;
    push(cyc + 7, 2'b00, 2'b10, 2'b00);
    drain("bounce_drained", 14);

    // Both keys fall on the same edge.
    e    = cyc + 1;
    key0 = 1'b0;
    key1 = 1'b0;
    push(e + 6, 2'b11, 2'b00, 2'b00);
    ticks(8);
    check("simul_down", {30'd0, mon_if.key_down}, 32'd3);
    key0 = 1'b1;
    key1 = 1'b1;
    push(cyc + 7, 2'b00, 2'b11, 2'b00);
    drain("simul_drained", 14);

    // Long press with a short release glitch: no second long pulse.
    e    = cyc + 1;
    key0 = 1'b0;
    push(e + 6, 2'b01, 2'b00, 2'b00);
    push(e + 26, 2'b00, 2'b00, 2'b01);
    push(e + 48, 2'b00, 2'b01, 2'b00);
    ticks(30);
    key0 = 1'b1;
    ticks(2);
    key0 = 1'b0;
    ticks(5);
    check("glitch_down", {30'd0, mon_if.key_down}, 32'd1);
    ticks(5);
    key0 = 1'b1;
    drain("glitch_drained", 14);

    // Reset while held: press abandoned silently, re-detected after release of reset.
    e    = cyc + 1;
    key0 = 1'b0;
    push(e + 6, 2'b01, 2'b00, 2'b00);
    ticks(10);
    check("pre_reset_down", {30'd0, mon_if.key_down}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    ticks(3);
    check_outputs_zero("mid_reset_late");
    rst_n = 1'b1;
    push(cyc + 7, 2'b01, 2'b00, 2'b00);
    ticks(10);
    check("post_reset_down", {30'd0, mon_if.key_down}, 32'd1);
    key0 = 1'b1;
    push(cyc + 7, 2'b00, 2'b01, 2'b00);
    drain("reset_drained", 14);
    check("final_down", {30'd0, mon_if.key_down}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 500000, meaning stable-level cycles required to accept a key change (10 ms at 50 MHz).
REQ-002 SHALL have parameter LONG_CYCLES, default 50000000, meaning press-accepted cycles before a long-press event (1 s at 50 MHz).
REQ-003 SHALL have port clk, input, 1, meaning the single system clock, 50 MHz nominal.
REQ-004 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 SHALL have port KEY0, input, 1, meaning raw board button 0, asynchronous, 0 = pressed.
REQ-006 SHALL have port KEY1, input, 1, meaning raw board button 1, asynchronous, 0 = pressed.
REQ-007 SHALL have port key_down, output, 2, meaning debounced level per key (bit n = KEYn), 1 = pressed.
REQ-008 SHALL have port key_press, output, 2, meaning a one-cycle pulse on an accepted press.
REQ-009 SHALL have port key_release, output, 2, meaning a one-cycle pulse on an accepted release.
REQ-010 SHALL have port key_long, output, 2, meaning a one-cycle pulse when a press has been held LONG_CYCLES.

Function
REQ-011 SHALL pass each KEYn through a 2-flop synchronizer; the inverted second-flop output is the raw pressed level.
REQ-012 SHALL run one independent channel per key; the two channels share no state, and simultaneous events on both keys are reported in the same cycle.
REQ-013 SHALL run a per-channel FSM with states IDLE, DEB_PRESS, HELD, LONG_HELD and DEB_REL.
REQ-014 IDLE: on raw pressed -> DEB_PRESS, debounce counter cleared.
REQ-015 DEB_PRESS: the counter increments while raw is pressed; raw released -> IDLE with no pulse; counter == DEB_CYCLES-1 with raw pressed -> HELD, key_press pulse, key_down=1, hold counter cleared.
REQ-016 HELD: the hold counter increments each cycle; when it reaches LONG_CYCLES-1 -> LONG_HELD and key_long pulses once; raw released -> DEB_REL, debounce counter cleared.
REQ-017 LONG_HELD: the hold counter stops (no wrap, no repeat pulse); raw released -> DEB_REL.
REQ-018 DEB_REL: raw pressed again -> return to the prior held state (HELD or LONG_HELD, tracked by a flag) with no pulse; counter == DEB_CYCLES-1 with raw released -> IDLE, key_release pulse, key_down=0.
REQ-019 In HELD, a release and the long-count terminal condition may coincide in the same cycle; release SHALL take priority, and key_long SHALL NOT pulse in that case.
REQ-020 Latency: key_press SHALL assert exactly DEB_CYCLES+2 cycles after the first clk edge that samples KEYn low, provided KEYn is held steady.
REQ-021 Counters SHALL be sized $clog2 of their limit and SHALL saturate, never wrap.
REQ-022 key_press, key_release and key_long SHALL each be registered, one cycle wide, and mutually exclusive per channel.

Reset
REQ-023 SHALL, while rst_n=0, hold synchronizer flops at 1 (released), FSM in IDLE, all counters 0, and key_down, key_press, key_release and key_long at 0.
REQ-024 If reset asserts mid-press, the channel SHALL abandon the press with no release pulse; if the key is still held after reset release, the channel SHALL report a new press after full debounce.

Structure
REQ-025 The shared package key_pkg SHALL hold the FSM state enum and the default DEB_CYCLES/LONG_CYCLES constants.
REQ-026 The design SHALL define sub-module key_channel (synchronizer + FSM + counters for one key) and instantiate it twice via generate.

Verification (DEB_CYCLES=4, LONG_CYCLES=20)
REQ-027 Clean press: KEY0 low for 10 cycles, then high -> key_press[0] pulses at cycle 6; key_release[0] pulses 6 cycles after the rising edge; key_long is never asserted.
REQ-028 Bounce: KEY1 toggles low/high every 2 cycles for 12 cycles, then stays low -> exactly one key_press[1], 6 cycles after the final falling edge.
REQ-029 Long press: KEY0 held low for 40 cycles -> key_press[0] at cycle 6, key_long[0] exactly once at cycle 26, no further pulses until release.
REQ-030 Simultaneous: KEY0 and KEY1 fall on the same edge -> key_press=2'b11 pulses in one cycle.
REQ-031 Reset mid-press: rst_n low while key_down[0]=1 with KEY0 held -> all outputs 0 during reset, no key_release; after reset release, key_press[0] pulses 6 cycles later.
